// File: rtl/fasater_sched_pkg.sv
// Shared encodings for the DPLL branch scheduler: datapath command opcodes
// and sequencer state values.
package fasater_sched_pkg;

    localparam logic [1:0] OP_ASSIGN    = 2'd0;
    localparam logic [1:0] OP_FLIP      = 2'd1;
    localparam logic [1:0] OP_BACKTRACK = 2'd2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RESOLVE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ISSUE   = ST_ISSUE,
        S_WAIT    = ST_WAIT,
        S_RESOLVE = ST_RESOLVE,
        S_DONE    = ST_DONE
    } sched_state_e;

endpackage

// File: rtl/dpll_tried_stack.sv
// Per-level "tried" bits: remembers whether the current value of a decision
// level has already been flipped, so a second conflict means backtrack.
module dpll_tried_stack #(
    parameter int NUM_VARS = 8,
    parameter int VW       = $clog2(NUM_VARS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_all,
    input  logic          set_en,
    input  logic          clr_en,
    input  logic [VW-1:0] idx,
    output logic          tried_bit
);

    logic [NUM_VARS-1:0] tried_reg;
    logic [NUM_VARS-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_hit
            assign hit[gi] = (idx == VW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tried_reg <= '0;
        end else if (clear_all) begin
            tried_reg <= '0;
        end else if (set_en) begin
            tried_reg <= tried_reg | hit;
        end else if (clr_en) begin
            tried_reg <= tried_reg & ~hit;
        end
    end

    assign tried_bit = |(tried_reg & hit);

endmodule

// File: rtl/dpll_branch_scheduler.sv
// Chronological DPLL sequencer: issues ASSIGN/FLIP/BACKTRACK commands to the
// search datapath and tracks decision level, tried bits and backtrack count.
module dpll_branch_scheduler
    import fasater_sched_pkg::*;
#(
    parameter int NUM_VARS = 8,
    parameter int VW       = $clog2(NUM_VARS),
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          eval_valid,
    input  logic          eval_conflict,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [1:0]    cmd_op,
    output logic [VW-1:0] cmd_var,
    output logic          cmd_val,
    output logic [VW-1:0] level,
    output logic          busy,
    output logic          done,
    output logic          sat,
    output logic [CW-1:0] bt_count
);

    localparam logic [VW-1:0] LAST_LEVEL = VW'(NUM_VARS - 1);
    localparam logic [CW-1:0] BT_MAX     = '1;

    sched_state_e  state_reg;
    logic [VW-1:0] level_reg;
    logic          cmd_valid_reg;
    logic [1:0]    cmd_op_reg;
    logic [VW-1:0] cmd_var_reg;
    logic          cmd_val_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          sat_reg;
    logic [CW-1:0] bt_count_reg;

    logic          start_en;
    logic          resolve_en;
    logic [VW-1:0] tried_idx;
    logic          tried_bit;

    assign start_en = start && (state_reg == S_IDLE || state_reg == S_DONE);

    // A conflict is resolved either at the current level (WAIT) or at the
    // level just below a popped one (RESOLVE); both use the same rule.
    assign tried_idx  = (state_reg == S_RESOLVE) ? level_reg - VW'(1) : level_reg;
    assign resolve_en = (state_reg == S_WAIT && eval_valid && eval_conflict) ||
                        (state_reg == S_RESOLVE && level_reg != '0);

    dpll_tried_stack #(
        .NUM_VARS (NUM_VARS),
        .VW       (VW)
    ) u_tried (
        .clk       (clk),
        .rst       (rst),
        .clear_all (start_en),
        .set_en    (resolve_en && !tried_bit),
        .clr_en    (resolve_en && tried_bit),
        .idx       (tried_idx),
        .tried_bit (tried_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            level_reg     <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_op_reg    <= OP_ASSIGN;
            cmd_var_reg   <= '0;
            cmd_val_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            sat_reg       <= 1'b0;
            bt_count_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        level_reg     <= '0;
                        bt_count_reg  <= '0;
                        done_reg      <= 1'b0;
                        sat_reg       <= 1'b0;
                        busy_reg      <= 1'b1;
                        cmd_op_reg    <= OP_ASSIGN;
                        cmd_var_reg   <= '0;
                        cmd_val_reg   <= 1'b0;
                        cmd_valid_reg <= 1'b1;
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        state_reg     <= (cmd_op_reg == OP_BACKTRACK) ? S_RESOLVE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eval_valid && !eval_conflict) begin
                        if (level_reg == LAST_LEVEL) begin
                            done_reg  <= 1'b1;
                            sat_reg   <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            level_reg     <= level_reg + VW'(1);
                            cmd_op_reg    <= OP_ASSIGN;
                            cmd_var_reg   <= level_reg + VW'(1);
                            cmd_val_reg   <= 1'b0;
                            cmd_valid_reg <= 1'b1;
                            state_reg     <= S_ISSUE;
                        end
                    end
                end
                S_RESOLVE: begin
                    if (level_reg == '0) begin
                        done_reg  <= 1'b1;
                        sat_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        level_reg <= level_reg - VW'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            if (resolve_en) begin
                cmd_var_reg   <= tried_idx;
                cmd_valid_reg <= 1'b1;
                state_reg     <= S_ISSUE;
                if (!tried_bit) begin
                    cmd_op_reg  <= OP_FLIP;
                    cmd_val_reg <= 1'b1;
                end else begin
                    cmd_op_reg  <= OP_BACKTRACK;
                    cmd_val_reg <= 1'b0;
                    if (bt_count_reg != BT_MAX) begin
                        bt_count_reg <= bt_count_reg + CW'(1);
                    end
                end
            end
        end
    end

    assign cmd_valid = cmd_valid_reg;
    assign cmd_op    = cmd_op_reg;
    assign cmd_var   = cmd_var_reg;
    assign cmd_val   = cmd_val_reg;
    assign level     = level_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign sat       = sat_reg;
    assign bt_count  = bt_count_reg;

endmodule

// File: tb/tb_dpll_branch_scheduler.sv
// Directed bench for dpll_branch_scheduler with NUM_VARS=4; commands are
// compared as packed {op[1:0], var[1:0], val}.
module tb_dpll_branch_scheduler;

    localparam int NV = 4;
    localparam int VW = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          eval_valid = 1'b0;
    logic          eval_conflict = 1'b0;
    logic          cmd_ready = 1'b1;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [VW-1:0] cmd_var;
    logic          cmd_val;
    logic [VW-1:0] level;
    logic          busy;
    logic          done;
    logic          sat;
    logic [CW-1:0] bt_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dpll_branch_scheduler #(.NUM_VARS(NV), .VW(VW), .CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .eval_valid    (eval_valid),
        .eval_conflict (eval_conflict),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_var       (cmd_var),
        .cmd_val       (cmd_val),
        .level         (level),
        .busy          (busy),
        .done          (done),
        .sat           (sat),
        .bt_count      (bt_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_eval(input logic c);
        eval_valid    = 1'b1;
        eval_conflict = c;
        tick();
        eval_valid    = 1'b0;
        eval_conflict = 1'b0;
    endtask

    // Waits (bounded) for an offered command and completes its handshake.
    task automatic take_cmd(output logic ok, output logic [4:0] c);
        ok = 1'b0;
        c  = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (cmd_valid && cmd_ready) begin
                ok = 1'b1;
                c  = {cmd_op, cmd_var, cmd_val};
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [26:0] got;
        do_reset();
        got = {cmd_valid, cmd_op, cmd_var, cmd_val, level, busy, done, sat, bt_count};
        checks++;
        if (got !== 27'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, 27'd0);
        end
        $display("reset: outputs=%h", got);
    endtask

    task automatic test_all_sat();
        logic       ok;
        logic [4:0] c;
        do_start();
        for (int i = 0; i < NV; i++) begin
            take_cmd(ok, c);
            checks++;
            if (!ok || c !== {2'd0, 2'(i), 1'b0}) begin
                errors++;
                $display("FAIL sat_assign%0d: got ok=%0d cmd=%b expected cmd=%b", i, ok, c, {2'd0, 2'(i), 1'b0});
            end
            $display("sat: cmd=%b", c);
            send_eval(1'b0);
        end
        checks++;
        if ({done, sat, busy, level, bt_count} !== {1'b1, 1'b1, 1'b0, 2'd3, 16'd0}) begin
            errors++;
            $display("FAIL sat_done: got done=%0d sat=%0d busy=%0d level=%0d bt=%0d expected 1 1 0 3 0",
                     done, sat, busy, level, bt_count);
        end
    endtask

    task automatic test_unsat();
        logic       ok;
        logic [4:0] c;
        logic [4:0] exp_cmd [3] = '{5'b00000, 5'b01001, 5'b10000};
        int         waited;
        do_start();
        for (int i = 0; i < 3; i++) begin
            take_cmd(ok, c);
            checks++;
            if (!ok || c !== exp_cmd[i]) begin
                errors++;
                $display("FAIL unsat_cmd%0d: got ok=%0d cmd=%b expected cmd=%b", i, ok, c, exp_cmd[i]);
            end
            $display("unsat: cmd=%b", c);
            if (i < 2) send_eval(1'b1);
        end
        waited = 0;
        while (!done && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if ({done, sat, busy, bt_count} !== {1'b1, 1'b0, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL unsat_done: got done=%0d sat=%0d busy=%0d bt=%0d expected 1 0 0 1",
                     done, sat, busy, bt_count);
        end
        // Restart straight out of DONE.
        do_start();
        checks++;
        if ({done, busy, bt_count, cmd_valid, cmd_op, cmd_var, cmd_val} !== {1'b0, 1'b1, 16'd0, 1'b1, 5'b00000}) begin
            errors++;
            $display("FAIL restart_from_done: got done=%0d busy=%0d bt=%0d valid=%0d cmd=%b expected 0 1 0 1 00000",
                     done, busy, bt_count, cmd_valid, {cmd_op, cmd_var, cmd_val});
        end
        do_reset();
    endtask

    task automatic test_backtrack();
        logic       ok;
        logic [4:0] c;
        logic [4:0] exp_cmd [5] = '{5'b00000, 5'b00010, 5'b00100, 5'b01101, 5'b10100};
        logic       ev [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_start();
        for (int i = 0; i < 5; i++) begin
            take_cmd(ok, c);
            checks++;
            if (!ok || c !== exp_cmd[i]) begin
                errors++;
                $display("FAIL bt_cmd%0d: got ok=%0d cmd=%b expected cmd=%b", i, ok, c, exp_cmd[i]);
            end
            $display("backtrack: cmd=%b", c);
            if (i < 4) begin
                send_eval(ev[i]);
                checks++;
                if (cmd_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL eval_latency%0d: got cmd_valid=%0d expected 1", i, cmd_valid);
                end
            end
        end
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL bt_gap: got cmd_valid=%0d expected 0", cmd_valid);
        end
        tick();
        checks++;
        if ({cmd_valid, cmd_op, cmd_var, cmd_val, level, bt_count} !== {1'b1, 5'b01011, 2'd1, 16'd1}) begin
            errors++;
            $display("FAIL bt_flip_below: got valid=%0d cmd=%b level=%0d bt=%0d expected 1 01011 1 1",
                     cmd_valid, {cmd_op, cmd_var, cmd_val}, level, bt_count);
        end
        do_reset();
    endtask

    task automatic test_backpressure();
        logic [4:0] held;
        cmd_ready = 1'b0;
        do_start();
        held = {cmd_op, cmd_var, cmd_val};
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cmd_valid !== 1'b1 || {cmd_op, cmd_var, cmd_val} !== 5'b00000) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%0d cmd=%b expected 1 00000", i, cmd_valid, {cmd_op, cmd_var, cmd_val});
            end
        end
        $display("backpressure: held cmd=%b", held);
        cmd_ready = 1'b1;
        tick();
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got cmd_valid=%0d expected 0", cmd_valid);
        end
        do_reset();
    endtask

    task automatic test_reset_midwait();
        logic        ok;
        logic [4:0]  c;
        logic [26:0] got;
        do_start();
        for (int i = 0; i < 3; i++) begin
            take_cmd(ok, c);
            if (i < 2) send_eval(1'b0);
        end
        checks++;
        if (level !== 2'd2 || !ok) begin
            errors++;
            $display("FAIL midwait_level: got level=%0d ok=%0d expected 2 1", level, ok);
        end
        #2 rst = 1'b1;
        #1;
        got = {cmd_valid, cmd_op, cmd_var, cmd_val, level, busy, done, sat, bt_count};
        checks++;
        if (got !== 27'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", got, 27'd0);
        end
        tick();
        rst = 1'b0;
        send_eval(1'b0);
        checks++;
        if ({cmd_valid, level, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL stray_eval: got valid=%0d level=%0d busy=%0d expected 0 0 0", cmd_valid, level, busy);
        end
        do_start();
        checks++;
        if ({cmd_valid, cmd_op, cmd_var, cmd_val} !== 6'b100000) begin
            errors++;
            $display("FAIL restart_after_reset: got valid=%0d cmd=%b expected 1 00000", cmd_valid, {cmd_op, cmd_var, cmd_val});
        end
        do_reset();
    endtask

    task automatic test_spurious();
        logic       ok;
        logic [4:0] c;
        cmd_ready = 1'b0;
        do_start();
        send_eval(1'b1);
        checks++;
        if ({cmd_valid, cmd_op, cmd_var, cmd_val, level, bt_count} !== {1'b1, 5'b00000, 2'd0, 16'd0}) begin
            errors++;
            $display("FAIL eval_in_issue: got valid=%0d cmd=%b level=%0d bt=%0d expected 1 00000 0 0",
                     cmd_valid, {cmd_op, cmd_var, cmd_val}, level, bt_count);
        end
        do_start();
        checks++;
        if ({cmd_valid, cmd_op, cmd_var, cmd_val, level, busy} !== {1'b1, 5'b00000, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL start_in_issue: got valid=%0d cmd=%b level=%0d busy=%0d expected 1 00000 0 1",
                     cmd_valid, {cmd_op, cmd_var, cmd_val}, level, busy);
        end
        cmd_ready = 1'b1;
        take_cmd(ok, c);
        do_start();
        send_eval(1'b0);
        take_cmd(ok, c);
        checks++;
        if (!ok || c !== 5'b00010 || level !== 2'd1) begin
            errors++;
            $display("FAIL start_in_wait: got ok=%0d cmd=%b level=%0d expected 1 00010 1", ok, c, level);
        end
        $display("spurious: next cmd=%b level=%0d", c, level);
        do_reset();
    endtask

    initial begin
        test_reset();
        test_all_sat();
        do_reset();
        test_unsat();
        test_backtrack();
        test_backpressure();
        test_reset_midwait();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
